// File: rtl/board_game_ctrl_pkg.sv
// Shared types for the N x N, K-in-a-row board controller: cell encoding,
// game states and scan direction codes.
package board_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    CHECK = 2'b01,
    WIN   = 2'b10,
    DRAW  = 2'b11
  } game_state_t;

  localparam logic [1:0] DIR_H = 2'd0;
  localparam logic [1:0] DIR_V = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_A = 2'd3;

endpackage

// File: rtl/board_game_ctrl_if.sv
// Move handshake and board status bundle; undo signals exist only when
// BOARD_UNDO_EN is defined.
interface board_game_ctrl_if #(parameter int N = 3);
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);

  logic            clear;
  logic            move_valid;
  logic [IW-1:0]   move_idx;
  logic            move_ready;
  logic            move_err;
  logic [2*NN-1:0] cells;
  logic            turn;
  logic [1:0]      game_state;
  logic            winner;
  logic [NN-1:0]   win_mask;
  logic [IW:0]     move_count;
`ifdef BOARD_UNDO_EN
  logic            undo_req;
  logic            undo_ok;

  modport master (output clear, move_valid, move_idx, undo_req,
                  input  move_ready, move_err, cells, turn, game_state,
                         winner, win_mask, move_count, undo_ok);
  modport slave  (input  clear, move_valid, move_idx, undo_req,
                  output move_ready, move_err, cells, turn, game_state,
                         winner, win_mask, move_count, undo_ok);
`else
  modport master (output clear, move_valid, move_idx,
                  input  move_ready, move_err, cells, turn, game_state,
                         winner, win_mask, move_count);
  modport slave  (input  clear, move_valid, move_idx,
                  output move_ready, move_err, cells, turn, game_state,
                         winner, win_mask, move_count);
`endif
endinterface

// File: rtl/board_game_ctrl_line_scanner.sv
// Sequential win scan through the last placed cell: one board position per
// cycle, four directions of 2K-1 offsets each, no row/column wrap-around.
module line_scanner
  import board_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    clear,
  input  logic                    start,
  input  logic [$clog2(N*N)-1:0]  last_idx,
  input  logic [1:0]              mark,
  input  logic [2*N*N-1:0]        cells,
  output logic                    done,
  output logic                    win,
  output logic [N*N-1:0]          win_mask
);
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int SW = $clog2(2*K - 1);
  localparam int RW = $clog2(K + 1);
  localparam int CW = 5;
  localparam logic [SW-1:0] LAST = SW'(2*K - 2);
  localparam logic signed [CW-1:0] NS = CW'(N);

  logic            busy_q;
  logic [1:0]      dir_q;
  logic [SW-1:0]   step_q;
  logic [RW-1:0]   run_q, run_n;
  logic [NN-1:0]   run_mask_q, mask_n;

  logic signed [CW-1:0] row0, col0, off, r, c;
  logic [IW-1:0]   lin;
  logic            on_board, hit, last_step;

  always_comb begin
    row0 = signed'(CW'(last_idx / IW'(N)));
    col0 = signed'(CW'(last_idx % IW'(N)));
    off  = signed'(CW'(step_q)) - signed'(CW'(K - 1));
    r = row0;
    c = col0;
    case (dir_q)
      DIR_H:   c = col0 + off;
      DIR_V:   r = row0 + off;
      DIR_D:   begin r = row0 + off; c = col0 + off; end
      default: begin r = row0 + off; c = col0 - off; end
    endcase
    // Bounds are checked on row and column separately so a line never wraps.
    on_board = !r[CW-1] && (r < NS) && !c[CW-1] && (c < NS);
    lin = on_board ? IW'(int'(r) * N + int'(c)) : '0;
    hit = on_board && (cells[{lin, 1'b0} +: 2] == mark);
    run_n  = '0;
    mask_n = '0;
    if (hit) begin
      run_n       = run_q + 1'b1;
      mask_n      = run_mask_q;
      mask_n[lin] = 1'b1;
    end
    last_step = (step_q == LAST);
    win       = busy_q && (run_n == RW'(K));
    done      = busy_q && (win || (dir_q == DIR_A && last_step));
    win_mask  = mask_n;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      busy_q     <= 1'b0;
      dir_q      <= DIR_H;
      step_q     <= '0;
      run_q      <= '0;
      run_mask_q <= '0;
    end else if (clear || start) begin
      busy_q     <= start && !clear;
      dir_q      <= DIR_H;
      step_q     <= '0;
      run_q      <= '0;
      run_mask_q <= '0;
    end else if (busy_q) begin
      if (done) begin
        busy_q <= 1'b0;
      end else if (last_step) begin
        dir_q      <= dir_q + 1'b1;
        step_q     <= '0;
        run_q      <= '0;
        run_mask_q <= '0;
      end else begin
        step_q     <= step_q + 1'b1;
        run_q      <= run_n;
        run_mask_q <= mask_n;
      end
    end
  end

endmodule

// File: rtl/board_game_ctrl.sv
// N x N, K-in-a-row two-player board controller: move handshake, turn keeping,
// win/draw FSM. Optional single-level undo under BOARD_UNDO_EN.
module board_game_ctrl
  import board_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic              clk,
  input  logic              Reset,
  board_game_ctrl_if.slave  bus
);
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);

  game_state_t     state_q, state_d;
  logic [2*NN-1:0] cells_q, cells_d;
  logic            turn_q, turn_d;
  logic            winner_q, winner_d;
  logic [NN-1:0]   win_mask_q, win_mask_d;
  logic [IW:0]     move_count_q, move_count_d;
  logic [IW-1:0]   last_idx_q, last_idx_d;
  logic            move_err_q, move_err_d;
  logic            move_ready_q;

  logic [1:0]      mark, sel_cell;
  logic            idx_ok, req, accept, reject;
  logic            scan_done, scan_win;
  logic [NN-1:0]   scan_mask;

`ifdef BOARD_UNDO_EN
  logic            undo_used_q, undo_used_d;
  logic            undo_ok_q, undo_ok_d;
  logic            undo_take;

  assign undo_take = bus.undo_req && (move_count_q != '0) && !undo_used_q &&
                     (state_q == PLAY || state_q == WIN);
  assign req       = bus.move_valid && (state_q == PLAY) && !undo_take;
  assign bus.undo_ok = undo_ok_q;
`else
  assign req       = bus.move_valid && (state_q == PLAY);
`endif

  assign mark     = turn_q ? MARK_O : MARK_X;
  assign idx_ok   = ({1'b0, bus.move_idx} < (IW+1)'(NN));
  assign sel_cell = idx_ok ? cells_q[{bus.move_idx, 1'b0} +: 2] : MARK_X;
  assign accept   = req && idx_ok && (sel_cell == EMPTY);
  assign reject   = req && !accept;

  line_scanner #(.N(N), .K(K)) u_scan (
    .clk      (clk),
    .Reset    (Reset),
    .clear    (bus.clear),
    .start    (accept),
    .last_idx (last_idx_d),
    .mark     (mark),
    .cells    (cells_q),
    .done     (scan_done),
    .win      (scan_win),
    .win_mask (scan_mask)
  );

  always_comb begin
    state_d      = state_q;
    cells_d      = cells_q;
    turn_d       = turn_q;
    winner_d     = winner_q;
    win_mask_d   = win_mask_q;
    move_count_d = move_count_q;
    last_idx_d   = last_idx_q;
    move_err_d   = reject;
`ifdef BOARD_UNDO_EN
    undo_used_d  = undo_used_q;
    undo_ok_d    = 1'b0;
`endif
    case (state_q)
      PLAY: if (accept) begin
        cells_d[{bus.move_idx, 1'b0} +: 2] = mark;
        move_count_d = move_count_q + 1'b1;
        last_idx_d   = bus.move_idx;
        state_d      = CHECK;
`ifdef BOARD_UNDO_EN
        undo_used_d  = 1'b0;
`endif
      end
      CHECK: if (scan_win) begin
        win_mask_d = scan_mask;
        winner_d   = turn_q;
        state_d    = WIN;
      end else if (scan_done) begin
        if (move_count_q == (IW+1)'(NN)) begin
          state_d = DRAW;
        end else begin
          state_d = PLAY;
          turn_d  = !turn_q;
        end
      end
      default: ;
    endcase
`ifdef BOARD_UNDO_EN
    // In WIN the turn was never flipped, so only a PLAY undo flips it back.
    if (undo_take) begin
      cells_d[{last_idx_q, 1'b0} +: 2] = EMPTY;
      move_count_d = move_count_q - 1'b1;
      if (state_q == PLAY) turn_d = !turn_q;
      state_d      = PLAY;
      win_mask_d   = '0;
      winner_d     = 1'b0;
      undo_ok_d    = 1'b1;
      undo_used_d  = 1'b1;
    end
`endif
    if (bus.clear) begin
      state_d      = PLAY;
      cells_d      = '0;
      turn_d       = 1'b0;
      winner_d     = 1'b0;
      win_mask_d   = '0;
      move_count_d = '0;
      last_idx_d   = '0;
      move_err_d   = 1'b0;
`ifdef BOARD_UNDO_EN
      undo_used_d  = 1'b0;
      undo_ok_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= PLAY;
      cells_q      <= '0;
      turn_q       <= 1'b0;
      winner_q     <= 1'b0;
      win_mask_q   <= '0;
      move_count_q <= '0;
      last_idx_q   <= '0;
      move_err_q   <= 1'b0;
      move_ready_q <= 1'b1;
`ifdef BOARD_UNDO_EN
      undo_used_q  <= 1'b0;
      undo_ok_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cells_q      <= cells_d;
      turn_q       <= turn_d;
      winner_q     <= winner_d;
      win_mask_q   <= win_mask_d;
      move_count_q <= move_count_d;
      last_idx_q   <= last_idx_d;
      move_err_q   <= move_err_d;
      move_ready_q <= (state_d == PLAY);
`ifdef BOARD_UNDO_EN
      undo_used_q  <= undo_used_d;
      undo_ok_q    <= undo_ok_d;
`endif
    end
  end

  assign bus.cells      = cells_q;
  assign bus.turn       = turn_q;
  assign bus.game_state = state_q;
  assign bus.winner     = winner_q;
  assign bus.win_mask   = win_mask_q;
  assign bus.move_count = move_count_q;
  assign bus.move_err   = move_err_q;
  assign bus.move_ready = move_ready_q;

endmodule

// File: tb/tb_board_game_ctrl.sv
// Directed bench for board_game_ctrl: a 3x3 and a 4x4 (K=3) instance side by
// side, hand-computed expectations.
module tb_board_game_ctrl;
  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  board_game_ctrl_if #(.N(3)) b3();
  board_game_ctrl_if #(.N(4)) b4();

  board_game_ctrl #(.N(3), .K(3)) dut3 (.clk(clk), .Reset(Reset), .bus(b3.slave));
  board_game_ctrl #(.N(4), .K(3)) dut4 (.clk(clk), .Reset(Reset), .bus(b4.slave));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] st(input int which);
    return (which == 3) ? b3.game_state : b4.game_state;
  endfunction

  task automatic drive(input int which, input logic v, input int idx);
    if (which == 3) begin b3.move_valid = v; b3.move_idx = 4'(idx); end
    else            begin b4.move_valid = v; b4.move_idx = 4'(idx); end
  endtask

  task automatic reset_all();
    Reset = 1'b1;
    b3.clear = 1'b0; b4.clear = 1'b0;
    drive(3, 1'b0, 0); drive(4, 1'b0, 0);
`ifdef BOARD_UNDO_EN
    b3.undo_req = 1'b0; b4.undo_req = 1'b0;
`endif
    repeat (2) @(negedge clk);
    Reset = 1'b0;
  endtask

  // one-cycle move request; returns at the negedge after the sampling edge
  task automatic pulse(input int which, input int idx);
    @(negedge clk);
    drive(which, 1'b1, idx);
    @(negedge clk);
    drive(which, 1'b0, 0);
  endtask

  task automatic wait_scan(input int which, output int cyc);
    cyc = 0;
    while (st(which) == 2'b01 && cyc < 60) begin
      cyc++;
      @(negedge clk);
    end
    expect_eq("scan_bound", 32'(cyc < 60), 32'd1);
  endtask

  task automatic play(input int which, input int mv[]);
    int cyc;
    foreach (mv[i]) begin
      pulse(which, mv[i]);
      wait_scan(which, cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;

    // reset values
    reset_all();
    expect_eq("rst_cells",  32'(b3.cells), 32'h0);
    expect_eq("rst_turn",   32'(b3.turn), 32'd0);
    expect_eq("rst_state",  32'(b3.game_state), 32'd0);
    expect_eq("rst_winner", 32'(b3.winner), 32'd0);
    expect_eq("rst_mask",   32'(b3.win_mask), 32'h0);
    expect_eq("rst_count",  32'(b3.move_count), 32'd0);
    expect_eq("rst_err",    32'(b3.move_err), 32'd0);
    expect_eq("rst_ready",  32'(b3.move_ready), 32'd1);

    // 3x3 row win: X 0,1,2 / O 3,4
    pulse(3, 0);
    expect_eq("mv1_state", 32'(b3.game_state), 32'd1);
    expect_eq("mv1_turn",  32'(b3.turn), 32'd0);
    expect_eq("mv1_cells", 32'(b3.cells), 32'h1);
    expect_eq("mv1_ready", 32'(b3.move_ready), 32'd0);
    wait_scan(3, cyc);
    expect_eq("mv1_scan_len", 32'(cyc), 32'd20);
    expect_eq("mv1_turn_flip", 32'(b3.turn), 32'd1);
    play(3, '{3, 1, 4});
    pulse(3, 2);
    wait_scan(3, cyc);
    expect_eq("win_scan_len", 32'(cyc), 32'd3);
    expect_eq("win_state",  32'(b3.game_state), 32'd2);
    expect_eq("win_winner", 32'(b3.winner), 32'd0);
    expect_eq("win_mask",   32'(b3.win_mask), 32'h007);
    expect_eq("win_ready",  32'(b3.move_ready), 32'd0);
    expect_eq("win_count",  32'(b3.move_count), 32'd5);
    expect_eq("win_cells",  32'(b3.cells), 32'h295);
    pulse(3, 5);
    expect_eq("win_ignore_err",   32'(b3.move_err), 32'd0);
    expect_eq("win_ignore_cells", 32'(b3.cells), 32'h295);
    expect_eq("win_absorb",       32'(b3.game_state), 32'd2);

    // occupied-cell rejection
    reset_all();
    play(3, '{4});
    pulse(3, 4);
    expect_eq("rej_err",   32'(b3.move_err), 32'd1);
    @(negedge clk);
    expect_eq("rej_err_1cyc", 32'(b3.move_err), 32'd0);
    expect_eq("rej_cell4", 32'(b3.cells[9:8]), 32'd1);
    expect_eq("rej_turn",  32'(b3.turn), 32'd1);
    expect_eq("rej_count", 32'(b3.move_count), 32'd1);
    expect_eq("rej_state", 32'(b3.game_state), 32'd0);
    // out-of-range index
    pulse(3, 12);
    expect_eq("oor_err",   32'(b3.move_err), 32'd1);
    expect_eq("oor_count", 32'(b3.move_count), 32'd1);

    // full board without a line -> DRAW
    reset_all();
    play(3, '{0, 1, 2, 4, 3, 5, 7, 6, 8});
    expect_eq("draw_state", 32'(b3.game_state), 32'd3);
    expect_eq("draw_count", 32'(b3.move_count), 32'd9);
    expect_eq("draw_turn",  32'(b3.turn), 32'd0);
    expect_eq("draw_mask",  32'(b3.win_mask), 32'h0);
    // clear from DRAW, then clear beating a move in PLAY
    @(negedge clk);
    b3.clear = 1'b1;
    @(negedge clk);
    expect_eq("clr_state", 32'(b3.game_state), 32'd0);
    expect_eq("clr_cells", 32'(b3.cells), 32'h0);
    expect_eq("clr_count", 32'(b3.move_count), 32'd0);
    drive(3, 1'b1, 4);
    @(negedge clk);
    b3.clear = 1'b0;
    drive(3, 1'b0, 0);
    expect_eq("clr_prio_cells", 32'(b3.cells), 32'h0);
    expect_eq("clr_prio_state", 32'(b3.game_state), 32'd0);
    expect_eq("clr_prio_err",   32'(b3.move_err), 32'd0);

    // 4x4 K=3 anti-diagonal 3,6,9
    reset_all();
    play(4, '{3, 0, 6, 1});
    pulse(4, 9);
    wait_scan(4, cyc);
    expect_eq("anti_scan_len", 32'(cyc), 32'd18);
    expect_eq("anti_state",  32'(b4.game_state), 32'd2);
    expect_eq("anti_winner", 32'(b4.winner), 32'd0);
    expect_eq("anti_mask",   32'(b4.win_mask), 32'h0248);

    // 4x4 K=3: X at 2,3 and 4 must not wrap into a line
    reset_all();
    play(4, '{2, 0, 3, 1, 4});
    expect_eq("wrap_state", 32'(b4.game_state), 32'd0);
    expect_eq("wrap_turn",  32'(b4.turn), 32'd1);
    expect_eq("wrap_count", 32'(b4.move_count), 32'd5);
    expect_eq("wrap_mask",  32'(b4.win_mask), 32'h0);

    // Reset asserted mid-CHECK
    reset_all();
    pulse(3, 4);
    repeat (5) @(negedge clk);
    expect_eq("midchk_state", 32'(b3.game_state), 32'd1);
    #2 Reset = 1'b1;
    #1;
    expect_eq("arst_cells", 32'(b3.cells), 32'h0);
    expect_eq("arst_state", 32'(b3.game_state), 32'd0);
    expect_eq("arst_count", 32'(b3.move_count), 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    repeat (25) @(negedge clk);
    expect_eq("arst_noresume", 32'(b3.game_state), 32'd0);
    expect_eq("arst_turn",     32'(b3.turn), 32'd0);

`ifdef BOARD_UNDO_EN
    reset_all();
    play(3, '{4});
    @(negedge clk);
    b3.undo_req = 1'b1;
    @(negedge clk);
    b3.undo_req = 1'b0;
    expect_eq("undo_ok",    32'(b3.undo_ok), 32'd1);
    expect_eq("undo_cells", 32'(b3.cells), 32'h0);
    expect_eq("undo_turn",  32'(b3.turn), 32'd0);
    expect_eq("undo_count", 32'(b3.move_count), 32'd0);
    @(negedge clk);
    expect_eq("undo_ok_1cyc", 32'(b3.undo_ok), 32'd0);
    b3.undo_req = 1'b1;
    @(negedge clk);
    b3.undo_req = 1'b0;
    expect_eq("undo_twice", 32'(b3.undo_ok), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
